cmd_arb: RTL and testbench
==========================

Name: cmd_arb

Overview:
- Arbiter and sequencer in front of cmd_cfg. It shares cmd_cfg's single command port between three requesters: the remote (UART_wrapper), an on-board safety requester, and an internal link-loss failsafe.
- Issues one command at a time over cmd_cfg's cmd_rdy/clr_cmd_rdy handshake and routes the response back to the requester that owns the grant.
- Aborts commands that cmd_cfg never acknowledges, such as invalid opcodes.

Parameters:
- LINK_W, 26: link-loss timer width; timer expires at 2^LINK_W-1 cycles with no remote command.
- RESP_W, 28: response-timeout counter width; timeout at 2^RESP_W-1 cycles in BUSY. Must exceed motor spin-up plus calibration time.
- NAK, 8'hEE: response byte returned to the requester on timeout abort.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rmt_rdy  in  1  remote command valid (from UART_wrapper)
- rmt_cmd  in  8  remote opcode
- rmt_data  in  16  remote data
- clr_rmt_rdy  out  1  1-cycle pulse: remote command latched
- rmt_resp  out  8  response byte to remote
- rmt_send_resp  out  1  1-cycle pulse: send rmt_resp
- sf_req  in  1  safety request (level, held until sf_ack)
- sf_cmd  in  8  safety opcode
- sf_data  in  16  safety data
- sf_ack  out  1  1-cycle pulse: safety command completed
- sf_nak  out  1  valid with sf_ack: 1 = aborted by timeout
- cmd_rdy  out  1  to cmd_cfg: command valid
- cmd  out  8  to cmd_cfg: opcode
- data  out  16  to cmd_cfg: data
- clr_cmd_rdy  in  1  from cmd_cfg: command digested
- resp  in  8  from cmd_cfg: response byte
- send_resp  in  1  from cmd_cfg: response valid
- motors_off  in  1  from cmd_cfg: motors currently off
- link_lost  out  1  failsafe tripped; cleared by next remote grant

Behaviour:
- Reset: state IDLE.
  - All outputs 0: cmd_rdy, cmd, data, clr_rmt_rdy, rmt_resp, rmt_send_resp, sf_ack, sf_nak, link_lost.
  - Counters 0; watchdog disarmed.
  - Reset mid-command drops cmd_rdy on the next edge; no response is forwarded.
- States: IDLE, BUSY, GAP.
- IDLE, arbitration with fixed priority failsafe > safety > remote:
  - Failsafe request pending: cmd<=8'h07 (EMER_LAND), data<=0.
  - Else sf_req: latch sf_cmd/sf_data.
  - Else rmt_rdy: latch rmt_cmd/rmt_data, pulse clr_rmt_rdy the same cycle.
  - On any grant: cmd_rdy<=1, record owner, clear response counter, go to BUSY. cmd_rdy is registered, so it is high 1 cycle after the grant.
- BUSY:
  - cmd_rdy held high; cmd/data stable; response counter increments each cycle.
  - send_resp: next cycle, forward to the owner.
    - Remote: rmt_resp<=resp, rmt_send_resp pulse.
    - Safety: sf_ack pulse, sf_nak=0.
    - Failsafe: response consumed internally.
  - clr_cmd_rdy: cmd_rdy<=0 at that edge. This guarantees cmd_cfg sees cmd_rdy low on its return to IDLE. Go to GAP.
  - send_resp and clr_cmd_rdy arrive in the same cycle from cmd_cfg; each is handled independently if they are separated.
  - Counter reaches 2^RESP_W-1 with no send_resp: cmd_rdy<=0, go to GAP.
    - Remote owner: rmt_resp=NAK with rmt_send_resp pulse.
    - Safety owner: sf_ack with sf_nak=1.
    - Failsafe owner: the failsafe request is retried.
- GAP: exactly 1 cycle, cmd_rdy low, then IDLE. Minimum command spacing is grant, 1 BUSY cycle, 1 GAP cycle.
- Watchdog:
  - Armed by the first remote grant after reset.
  - Link counter clears on every remote grant and increments otherwise, saturating.
  - At 2^LINK_W-1, armed and motors_off=0: set failsafe pending and link_lost=1, disarm. Fires once per loss.
  - motors_off=1 at expiry: no request; the watchdog stays armed.
- Requester stability: rmt_rdy/sf_req asserted while BUSY simply wait; there is no preemption. The remote may be starved by a continuously asserted sf_req; this is accepted.

Optional Feature:
- FS_MTR_OFF_EN defined: after the failsafe EMER_LAND completes, the link counter restarts. If it expires again with no remote grant, the failsafe issues 8'h08 (MOTORS_OFF), data 0, at top priority. A remote grant in between cancels it.
- FS_MTR_OFF_EN undefined: the failsafe issues only EMER_LAND.

Test Plan (LINK_W=6, RESP_W=8):
- Remote cmd 8'h02 data 16'h0123 into a cmd_cfg model → clr_rmt_rdy pulse; cmd=02, data=0123, cmd_rdy 1 cycle later; after send_resp(A5) → rmt_resp=A5 pulse; cmd_rdy low the cycle after clr_cmd_rdy.
- sf_req (cmd 07) and rmt_rdy (cmd 05) raised the same cycle → safety issued first; remote issued after GAP; sf_ack/sf_nak=0 then rmt_resp=A5.
- Remote cmd 8'h0F, model never responds → cmd_rdy drops after 255 BUSY cycles; rmt_resp=EE pulse; next request is served.
- Remote grant, then 63 idle cycles with motors_off=0 → link_lost=1; EMER_LAND (07, 0000) issued; no rmt_send_resp; new remote grant clears link_lost.
- Same scenario with motors_off=1 → no failsafe command; link_lost stays 0.
- rst asserted mid-BUSY → all outputs 0 the next cycle; with FS_MTR_OFF_EN, two expiries → 07 then 08 issued.

Source files
------------

// File: rtl/cmd_arb_if.sv
// Command arbiter bus: the remote link, the safety requester and the cmd_cfg port.
// master is the arbiter's view; slave is the view of the surrounding requesters and cmd_cfg.
interface cmd_arb_if;
    logic        rmt_rdy;
    logic [7:0]  rmt_cmd;
    logic [15:0] rmt_data;
    logic        clr_rmt_rdy;
    logic [7:0]  rmt_resp;
    logic        rmt_send_resp;

    logic        sf_req;
    logic [7:0]  sf_cmd;
    logic [15:0] sf_data;
    logic        sf_ack;
    logic        sf_nak;

    logic        cmd_rdy;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        send_resp;
    logic        motors_off;
    logic        link_lost;

    modport master (
        input  rmt_rdy, rmt_cmd, rmt_data, sf_req, sf_cmd, sf_data,
               clr_cmd_rdy, resp, send_resp, motors_off,
        output clr_rmt_rdy, rmt_resp, rmt_send_resp, sf_ack, sf_nak,
               cmd_rdy, cmd, data, link_lost
    );

    modport slave (
        output rmt_rdy, rmt_cmd, rmt_data, sf_req, sf_cmd, sf_data,
               clr_cmd_rdy, resp, send_resp, motors_off,
        input  clr_rmt_rdy, rmt_resp, rmt_send_resp, sf_ack, sf_nak,
               cmd_rdy, cmd, data, link_lost
    );
endinterface

// File: rtl/cmd_arb.sv
// Shares cmd_cfg's command port between failsafe, safety and remote requesters; aborts unanswered commands.
// Define FS_MTR_OFF_EN to follow a completed failsafe EMER_LAND with MOTORS_OFF on a second link-loss expiry.
module cmd_arb #(
    parameter int unsigned LINK_W = 26,
    parameter int unsigned RESP_W = 28,
    parameter logic [7:0]  NAK    = 8'hEE
) (
    input  logic      clk,
    input  logic      rst,
    cmd_arb_if.master bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam logic [1:0] OWN_RMT = 2'd0;
    localparam logic [1:0] OWN_SF  = 2'd1;
    localparam logic [1:0] OWN_FS  = 2'd2;

    localparam logic [7:0] EMER_LAND  = 8'h07;
    localparam logic [7:0] MOTORS_OFF = 8'h08;

    localparam logic [LINK_W-1:0] LINK_MAX = '1;
    localparam logic [RESP_W-1:0] RESP_MAX = '1;

    logic [1:0]        state_q, state_d;
    logic [1:0]        owner_q, owner_d;
    logic              cmd_rdy_q, cmd_rdy_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [15:0]       data_q, data_d;
    logic [RESP_W-1:0] resp_cnt_q, resp_cnt_d;
    logic              resp_seen_q, resp_seen_d;
    logic [7:0]        rmt_resp_q, rmt_resp_d;
    logic              rmt_send_resp_q, rmt_send_resp_d;
    logic              sf_ack_q, sf_ack_d;
    logic              sf_nak_q, sf_nak_d;
    logic [LINK_W-1:0] link_cnt_q, link_cnt_d;
    logic              armed_q, armed_d;
    logic              link_lost_q, link_lost_d;
    logic              fs_pend_q, fs_pend_d;
`ifdef FS_MTR_OFF_EN
    logic              fs_stage_q, fs_stage_d;
    logic              mo_arm_q, mo_arm_d;
`endif
    logic              rmt_grant;
    logic [7:0]        fs_op;

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        cmd_rdy_d       = cmd_rdy_q;
        cmd_d           = cmd_q;
        data_d          = data_q;
        resp_cnt_d      = resp_cnt_q;
        resp_seen_d     = resp_seen_q;
        rmt_resp_d      = rmt_resp_q;
        rmt_send_resp_d = 1'b0;
        sf_ack_d        = 1'b0;
        sf_nak_d        = 1'b0;
        link_cnt_d      = link_cnt_q;
        armed_d         = armed_q;
        link_lost_d     = link_lost_q;
        fs_pend_d       = fs_pend_q;
        rmt_grant       = 1'b0;
`ifdef FS_MTR_OFF_EN
        fs_stage_d      = fs_stage_q;
        mo_arm_d        = mo_arm_q;
        fs_op           = fs_stage_q ? MOTORS_OFF : EMER_LAND;
`else
        fs_op           = EMER_LAND;
`endif

        case (state_q)
            ST_IDLE: begin
                if (fs_pend_q) begin
                    cmd_d     = fs_op;
                    data_d    = '0;
                    owner_d   = OWN_FS;
                    fs_pend_d = 1'b0;
                end else if (bus.sf_req) begin
                    cmd_d   = bus.sf_cmd;
                    data_d  = bus.sf_data;
                    owner_d = OWN_SF;
                end else if (bus.rmt_rdy) begin
                    cmd_d     = bus.rmt_cmd;
                    data_d    = bus.rmt_data;
                    owner_d   = OWN_RMT;
                    rmt_grant = 1'b1;
                end
                if (fs_pend_q || bus.sf_req || bus.rmt_rdy) begin
                    cmd_rdy_d   = 1'b1;
                    resp_cnt_d  = '0;
                    resp_seen_d = 1'b0;
                    state_d     = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (resp_cnt_q != RESP_MAX) resp_cnt_d = resp_cnt_q + 1'b1;
                if (bus.send_resp) begin
                    resp_seen_d = 1'b1;
                    if (owner_q == OWN_RMT) begin
                        rmt_resp_d      = bus.resp;
                        rmt_send_resp_d = 1'b1;
                    end else if (owner_q == OWN_SF) begin
                        sf_ack_d = 1'b1;
                    end
                end
                // A late response still clears the abort path; only an unanswered command is NAKed.
                if (bus.clr_cmd_rdy) begin
                    cmd_rdy_d = 1'b0;
                    state_d   = ST_GAP;
                end else if (!bus.send_resp && resp_cnt_q >= RESP_MAX - 1'b1) begin
                    cmd_rdy_d = 1'b0;
                    state_d   = ST_GAP;
                    if (!resp_seen_q) begin
                        if (owner_q == OWN_RMT) begin
                            rmt_resp_d      = NAK;
                            rmt_send_resp_d = 1'b1;
                        end else if (owner_q == OWN_SF) begin
                            sf_ack_d = 1'b1;
                            sf_nak_d = 1'b1;
                        end else begin
                            fs_pend_d = 1'b1;
                        end
                    end
                end
            end
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Expiry is taken on the edge where the counter reaches its top value, and again while saturated.
        if (rmt_grant) begin
            link_cnt_d  = '0;
            armed_d     = 1'b1;
            link_lost_d = 1'b0;
`ifdef FS_MTR_OFF_EN
            mo_arm_d    = 1'b0;
`endif
        end else begin
            if (link_cnt_q != LINK_MAX) link_cnt_d = link_cnt_q + 1'b1;
            if (link_cnt_q >= LINK_MAX - 1'b1) begin
                if (armed_q && !bus.motors_off) begin
                    fs_pend_d   = 1'b1;
                    link_lost_d = 1'b1;
                    armed_d     = 1'b0;
`ifdef FS_MTR_OFF_EN
                    fs_stage_d  = 1'b0;
                end else if (mo_arm_q) begin
                    fs_pend_d  = 1'b1;
                    fs_stage_d = 1'b1;
                    mo_arm_d   = 1'b0;
`endif
                end
            end
        end

`ifdef FS_MTR_OFF_EN
        if (state_q == ST_BUSY && bus.send_resp && owner_q == OWN_FS && !fs_stage_q) begin
            link_cnt_d = '0;
            mo_arm_d   = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            owner_q         <= OWN_RMT;
            cmd_rdy_q       <= 1'b0;
            cmd_q           <= '0;
            data_q          <= '0;
            resp_cnt_q      <= '0;
            resp_seen_q     <= 1'b0;
            rmt_resp_q      <= '0;
            rmt_send_resp_q <= 1'b0;
            sf_ack_q        <= 1'b0;
            sf_nak_q        <= 1'b0;
            link_cnt_q      <= '0;
            armed_q         <= 1'b0;
            link_lost_q     <= 1'b0;
            fs_pend_q       <= 1'b0;
`ifdef FS_MTR_OFF_EN
            fs_stage_q      <= 1'b0;
            mo_arm_q        <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            cmd_rdy_q       <= cmd_rdy_d;
            cmd_q           <= cmd_d;
            data_q          <= data_d;
            resp_cnt_q      <= resp_cnt_d;
            resp_seen_q     <= resp_seen_d;
            rmt_resp_q      <= rmt_resp_d;
            rmt_send_resp_q <= rmt_send_resp_d;
            sf_ack_q        <= sf_ack_d;
            sf_nak_q        <= sf_nak_d;
            link_cnt_q      <= link_cnt_d;
            armed_q         <= armed_d;
            link_lost_q     <= link_lost_d;
            fs_pend_q       <= fs_pend_d;
`ifdef FS_MTR_OFF_EN
            fs_stage_q      <= fs_stage_d;
            mo_arm_q        <= mo_arm_d;
`endif
        end
    end

    assign bus.clr_rmt_rdy   = rmt_grant & ~rst;
    assign bus.cmd_rdy       = cmd_rdy_q;
    assign bus.cmd           = cmd_q;
    assign bus.data          = data_q;
    assign bus.rmt_resp      = rmt_resp_q;
    assign bus.rmt_send_resp = rmt_send_resp_q;
    assign bus.sf_ack        = sf_ack_q;
    assign bus.sf_nak        = sf_nak_q;
    assign bus.link_lost     = link_lost_q;
endmodule

// File: tb/tb_cmd_arb.sv
// Directed bench for cmd_arb with LINK_W=6, RESP_W=8; cmd_cfg is played by hand from the stimulus tasks.
module tb_cmd_arb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    cmd_arb_if bus ();

    cmd_arb #(.LINK_W(6), .RESP_W(8), .NAK(8'hEE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic mo);
        rst = 1'b1;
        bus.rmt_rdy = 0; bus.rmt_cmd = 0; bus.rmt_data = 0;
        bus.sf_req = 0; bus.sf_cmd = 0; bus.sf_data = 0;
        bus.clr_cmd_rdy = 0; bus.resp = 0; bus.send_resp = 0;
        bus.motors_off = mo;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic respond(input logic [7:0] r);
        bus.send_resp = 1; bus.clr_cmd_rdy = 1; bus.resp = r;
        tick();
        bus.send_resp = 0; bus.clr_cmd_rdy = 0;
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        rst = 1'b1; bus.rmt_rdy = 1; bus.rmt_cmd = 8'h02;
        tick();
        #1;
        total++; if (bus.cmd_rdy !== 1'b0) begin bad++; $display("FAIL reset_cmd_rdy got=%0h want=0", bus.cmd_rdy); end
        total++; if (bus.cmd !== 8'h00) begin bad++; $display("FAIL reset_cmd got=%0h want=00", bus.cmd); end
        total++; if (bus.clr_rmt_rdy !== 1'b0) begin bad++; $display("FAIL reset_clr_rmt_rdy got=%0h want=0", bus.clr_rmt_rdy); end
        total++; if (bus.link_lost !== 1'b0) begin bad++; $display("FAIL reset_link_lost got=%0h want=0", bus.link_lost); end
        bus.rmt_rdy = 0;
    endtask

    task automatic test_remote();
        do_reset(1'b0);
        bus.rmt_rdy = 1; bus.rmt_cmd = 8'h02; bus.rmt_data = 16'h0123;
        #1;
        total++; if (bus.clr_rmt_rdy !== 1'b1) begin bad++; $display("FAIL rmt_clr got=%0h want=1", bus.clr_rmt_rdy); end
        total++; if (bus.cmd_rdy !== 1'b0) begin bad++; $display("FAIL rmt_cmd_rdy_early got=%0h want=0", bus.cmd_rdy); end
        tick();
        bus.rmt_rdy = 0;
        #1;
        total++; if (bus.cmd_rdy !== 1'b1) begin bad++; $display("FAIL rmt_cmd_rdy got=%0h want=1", bus.cmd_rdy); end
        total++; if (bus.cmd !== 8'h02) begin bad++; $display("FAIL rmt_cmd got=%0h want=02", bus.cmd); end
        total++; if (bus.data !== 16'h0123) begin bad++; $display("FAIL rmt_data got=%0h want=0123", bus.data); end
        total++; if (bus.clr_rmt_rdy !== 1'b0) begin bad++; $display("FAIL rmt_clr_busy got=%0h want=0", bus.clr_rmt_rdy); end
        respond(8'hA5);
        total++; if (bus.cmd_rdy !== 1'b0) begin bad++; $display("FAIL rmt_cmd_rdy_drop got=%0h want=0", bus.cmd_rdy); end
        total++; if (bus.rmt_send_resp !== 1'b1) begin bad++; $display("FAIL rmt_send_resp got=%0h want=1", bus.rmt_send_resp); end
        total++; if (bus.rmt_resp !== 8'hA5) begin bad++; $display("FAIL rmt_resp got=%0h want=a5", bus.rmt_resp); end
        tick();
        total++; if (bus.rmt_send_resp !== 1'b0) begin bad++; $display("FAIL rmt_send_resp_pulse got=%0h want=0", bus.rmt_send_resp); end
    endtask

    task automatic test_priority();
        do_reset(1'b0);
        bus.sf_req = 1; bus.sf_cmd = 8'h07; bus.sf_data = 16'h1111;
        bus.rmt_rdy = 1; bus.rmt_cmd = 8'h05; bus.rmt_data = 16'h2222;
        #1;
        total++; if (bus.clr_rmt_rdy !== 1'b0) begin bad++; $display("FAIL prio_clr_rmt got=%0h want=0", bus.clr_rmt_rdy); end
        tick();
        total++; if (bus.cmd !== 8'h07) begin bad++; $display("FAIL prio_sf_cmd got=%0h want=07", bus.cmd); end
        total++; if (bus.data !== 16'h1111) begin bad++; $display("FAIL prio_sf_data got=%0h want=1111", bus.data); end
        respond(8'h5A);
        bus.sf_req = 0;
        total++; if (bus.sf_ack !== 1'b1) begin bad++; $display("FAIL prio_sf_ack got=%0h want=1", bus.sf_ack); end
        total++; if (bus.sf_nak !== 1'b0) begin bad++; $display("FAIL prio_sf_nak got=%0h want=0", bus.sf_nak); end
        total++; if (bus.rmt_send_resp !== 1'b0) begin bad++; $display("FAIL prio_rmt_resp_leak got=%0h want=0", bus.rmt_send_resp); end
        total++; if (bus.clr_rmt_rdy !== 1'b0) begin bad++; $display("FAIL prio_gap_clr got=%0h want=0", bus.clr_rmt_rdy); end
        tick();
        total++; if (bus.clr_rmt_rdy !== 1'b1) begin bad++; $display("FAIL prio_rmt_clr got=%0h want=1", bus.clr_rmt_rdy); end
        total++; if (bus.sf_ack !== 1'b0) begin bad++; $display("FAIL prio_sf_ack_pulse got=%0h want=0", bus.sf_ack); end
        tick();
        bus.rmt_rdy = 0;
        total++; if (bus.cmd !== 8'h05) begin bad++; $display("FAIL prio_rmt_cmd got=%0h want=05", bus.cmd); end
        total++; if (bus.cmd_rdy !== 1'b1) begin bad++; $display("FAIL prio_rmt_cmd_rdy got=%0h want=1", bus.cmd_rdy); end
        respond(8'hA5);
        total++; if (bus.rmt_resp !== 8'hA5) begin bad++; $display("FAIL prio_rmt_resp got=%0h want=a5", bus.rmt_resp); end
        total++; if (bus.sf_ack !== 1'b0) begin bad++; $display("FAIL prio_sf_ack_leak got=%0h want=0", bus.sf_ack); end
        tick();
    endtask

    task automatic test_timeout();
        do_reset(1'b1);
        bus.rmt_rdy = 1; bus.rmt_cmd = 8'h0F; bus.rmt_data = 16'h0000;
        tick();
        bus.rmt_rdy = 0;
        total++; if (bus.cmd_rdy !== 1'b1) begin bad++; $display("FAIL to_cmd_rdy got=%0h want=1", bus.cmd_rdy); end
        repeat (254) tick();
        total++; if (bus.cmd_rdy !== 1'b1) begin bad++; $display("FAIL to_cmd_rdy_254 got=%0h want=1", bus.cmd_rdy); end
        total++; if (bus.rmt_send_resp !== 1'b0) begin bad++; $display("FAIL to_early_resp got=%0h want=0", bus.rmt_send_resp); end
        tick();
        total++; if (bus.cmd_rdy !== 1'b0) begin bad++; $display("FAIL to_cmd_rdy_255 got=%0h want=0", bus.cmd_rdy); end
        total++; if (bus.rmt_send_resp !== 1'b1) begin bad++; $display("FAIL to_nak_pulse got=%0h want=1", bus.rmt_send_resp); end
        total++; if (bus.rmt_resp !== 8'hEE) begin bad++; $display("FAIL to_nak_byte got=%0h want=ee", bus.rmt_resp); end
        tick();
        bus.rmt_rdy = 1; bus.rmt_cmd = 8'h03;
        tick();
        bus.rmt_rdy = 0;
        total++; if (bus.cmd !== 8'h03 || bus.cmd_rdy !== 1'b1) begin bad++; $display("FAIL to_next_grant got=%0h/%0h want=03/1", bus.cmd, bus.cmd_rdy); end
        respond(8'h3C);
        total++; if (bus.rmt_resp !== 8'h3C) begin bad++; $display("FAIL to_next_resp got=%0h want=3c", bus.rmt_resp); end
        tick();
        bus.sf_req = 1; bus.sf_cmd = 8'h09;
        tick();
        repeat (255) tick();
        bus.sf_req = 0;
        total++; if (bus.sf_ack !== 1'b1) begin bad++; $display("FAIL to_sf_ack got=%0h want=1", bus.sf_ack); end
        total++; if (bus.sf_nak !== 1'b1) begin bad++; $display("FAIL to_sf_nak got=%0h want=1", bus.sf_nak); end
        tick();
        total++; if (bus.sf_ack !== 1'b0) begin bad++; $display("FAIL to_sf_ack_pulse got=%0h want=0", bus.sf_ack); end
    endtask

    task automatic test_watchdog();
        do_reset(1'b0);
        bus.rmt_rdy = 1; bus.rmt_cmd = 8'h01; bus.rmt_data = 16'hBEEF;
        tick();
        bus.rmt_rdy = 0;
        respond(8'h11);
        repeat (61) tick();
        total++; if (bus.link_lost !== 1'b0) begin bad++; $display("FAIL wd_early got=%0h want=0", bus.link_lost); end
        tick();
        total++; if (bus.link_lost !== 1'b1) begin bad++; $display("FAIL wd_link_lost got=%0h want=1", bus.link_lost); end
        tick();
        total++; if (bus.cmd_rdy !== 1'b1) begin bad++; $display("FAIL wd_fs_cmd_rdy got=%0h want=1", bus.cmd_rdy); end
        total++; if (bus.cmd !== 8'h07) begin bad++; $display("FAIL wd_fs_cmd got=%0h want=07", bus.cmd); end
        total++; if (bus.data !== 16'h0000) begin bad++; $display("FAIL wd_fs_data got=%0h want=0000", bus.data); end
        respond(8'hA5);
        total++; if (bus.rmt_send_resp !== 1'b0) begin bad++; $display("FAIL wd_fs_resp_leak got=%0h want=0", bus.rmt_send_resp); end
        total++; if (bus.sf_ack !== 1'b0) begin bad++; $display("FAIL wd_fs_ack_leak got=%0h want=0", bus.sf_ack); end
        tick();
        bus.rmt_rdy = 1; bus.rmt_cmd = 8'h04;
        tick();
        bus.rmt_rdy = 0;
        total++; if (bus.link_lost !== 1'b0) begin bad++; $display("FAIL wd_clear got=%0h want=0", bus.link_lost); end
        total++; if (bus.cmd !== 8'h04) begin bad++; $display("FAIL wd_rmt_cmd got=%0h want=04", bus.cmd); end
        respond(8'h00);
        tick();
    endtask

    task automatic test_motors_off();
        do_reset(1'b1);
        bus.rmt_rdy = 1; bus.rmt_cmd = 8'h01;
        tick();
        bus.rmt_rdy = 0;
        respond(8'h11);
        repeat (70) tick();
        total++; if (bus.link_lost !== 1'b0) begin bad++; $display("FAIL mo_link_lost got=%0h want=0", bus.link_lost); end
        total++; if (bus.cmd_rdy !== 1'b0) begin bad++; $display("FAIL mo_cmd_rdy got=%0h want=0", bus.cmd_rdy); end
        bus.motors_off = 0;
        tick();
        total++; if (bus.link_lost !== 1'b1) begin bad++; $display("FAIL mo_still_armed got=%0h want=1", bus.link_lost); end
        tick();
        total++; if (bus.cmd !== 8'h07 || bus.cmd_rdy !== 1'b1) begin bad++; $display("FAIL mo_fs_grant got=%0h/%0h want=07/1", bus.cmd, bus.cmd_rdy); end
    endtask

    task automatic test_reset_mid_busy();
        do_reset(1'b0);
        bus.rmt_rdy = 1; bus.rmt_cmd = 8'h06; bus.rmt_data = 16'h4242;
        tick();
        tick();
        rst = 1'b1; bus.send_resp = 1; bus.resp = 8'hA5;
        tick();
        total++; if (bus.cmd_rdy !== 1'b0) begin bad++; $display("FAIL rstb_cmd_rdy got=%0h want=0", bus.cmd_rdy); end
        total++; if (bus.data !== 16'h0000) begin bad++; $display("FAIL rstb_data got=%0h want=0000", bus.data); end
        total++; if (bus.rmt_send_resp !== 1'b0) begin bad++; $display("FAIL rstb_send_resp got=%0h want=0", bus.rmt_send_resp); end
        total++; if (bus.rmt_resp !== 8'h00) begin bad++; $display("FAIL rstb_resp got=%0h want=00", bus.rmt_resp); end
        total++; if (bus.clr_rmt_rdy !== 1'b0) begin bad++; $display("FAIL rstb_clr got=%0h want=0", bus.clr_rmt_rdy); end
        bus.send_resp = 0; bus.rmt_rdy = 0;
        rst = 1'b0;
    endtask

`ifdef FS_MTR_OFF_EN
    task automatic test_mtr_off();
        bit seen;
        do_reset(1'b0);
        bus.rmt_rdy = 1; bus.rmt_cmd = 8'h01;
        tick();
        bus.rmt_rdy = 0;
        respond(8'h11);
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin tick(); seen = bus.cmd_rdy; end
        total++; if (seen !== 1'b1 || bus.cmd !== 8'h07) begin bad++; $display("FAIL mtr_land got=%0h/%0h want=1/07", seen, bus.cmd); end
        respond(8'h00);
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin tick(); seen = bus.cmd_rdy; end
        total++; if (seen !== 1'b1 || bus.cmd !== 8'h08) begin bad++; $display("FAIL mtr_off got=%0h/%0h want=1/08", seen, bus.cmd); end
        respond(8'h00);
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_remote();
        test_priority();
        test_timeout();
        test_watchdog();
        test_motors_off();
        test_reset_mid_busy();
`ifdef FS_MTR_OFF_EN
        test_mtr_off();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "time limit");
    end
endmodule
